// File: rtl/pulse_meter_if.sv
// Result channel of pulse_meter: one measured pulse per valid/ready transfer.
// The master drives the result; the slave returns ready.
interface pulse_meter_if #(
   parameter int WIDTH = 16
);
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_count;
   logic             m_overflow;

   modport master (
      output m_valid,
      output m_count,
      output m_overflow,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_count,
      input  m_overflow,
      output m_ready
   );
endinterface

// File: rtl/pulse_meter.sv
// Measures how many clock cycles a level stays high and reports each completed pulse.
// It holds one result; a result that arrives while that buffer is full is counted in dropped.
module pulse_meter #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sense,
   input  logic       clear,
   output logic       measuring,
   output logic [7:0] dropped,
   pulse_meter_if.master res
);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state;
   logic             sense_q;
   logic [WIDTH-1:0] count;
   logic             over;
   logic             complete;

   assign complete  = (state == MEASURE) && !sense;
   assign measuring = (state == MEASURE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         sense_q        <= 1'b1;
         count          <= '0;
         over           <= 1'b0;
         res.m_valid    <= 1'b0;
         res.m_count    <= '0;
         res.m_overflow <= 1'b0;
         dropped        <= '0;
      end else if (clear) begin
         // sense_q forced high so a level already high is not mistaken for a new edge
         state       <= IDLE;
         sense_q     <= 1'b1;
         res.m_valid <= 1'b0;
         dropped     <= '0;
      end else begin
         sense_q <= sense;
         case (state)
            IDLE: begin
               if (sense && !sense_q) begin
                  state <= MEASURE;
                  count <= WIDTH'(1);
                  over  <= 1'b0;
               end
            end
            MEASURE: begin
               if (sense) begin
                  if (count == '1) over <= 1'b1;
                  else             count <= count + WIDTH'(1);
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A completion may refill the buffer on the same edge it is being drained
         if (complete) begin
            if (!res.m_valid || res.m_ready) begin
               res.m_valid    <= 1'b1;
               res.m_count    <= count;
               res.m_overflow <= over;
            end else if (dropped != 8'hFF) begin
               dropped <= dropped + 8'd1;
            end
         end else if (res.m_valid && res.m_ready) begin
            res.m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a 16-bit instance for the handshake, drop, clear and
// reset cases, plus a 4-bit instance for saturation of the count.
module tb_pulse_meter;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       sense  = 1'b0;
   logic       clear  = 1'b0;
   logic       sense4 = 1'b0;
   logic       clear4 = 1'b0;
   logic       meas;
   logic       meas4;
   logic [7:0] drop;
   logic [7:0] drop4;

   int total = 0;
   int bad   = 0;

   pulse_meter_if #(.WIDTH(16)) bus ();
   pulse_meter_if #(.WIDTH(4))  bus4 ();

   pulse_meter #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .sense     (sense),
      .clear     (clear),
      .measuring (meas),
      .dropped   (drop),
      .res       (bus)
   );

   pulse_meter #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .sense     (sense4),
      .clear     (clear4),
      .measuring (meas4),
      .dropped   (drop4),
      .res       (bus4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      bus.m_ready  = 1'b0;
      bus4.m_ready = 1'b1;

      // reset state
      repeat (3) tick();
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_count", 32'(bus.m_count), 32'd0);
      chk("rst_ovf", 32'(bus.m_overflow), 32'd0);
      chk("rst_meas", 32'(meas), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      reset = 1'b1;
      tick();

      // 5-cycle pulse, ready tied high
      bus.m_ready = 1'b1;
      sense = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1_meas_hi", 32'(meas), 32'd1);
      end
      sense = 1'b0;
      tick();
      chk("t1_valid", 32'(bus.m_valid), 32'd1);
      chk("t1_count", 32'(bus.m_count), 32'd5);
      chk("t1_ovf", 32'(bus.m_overflow), 32'd0);
      chk("t1_meas_lo", 32'(meas), 32'd0);
      tick();
      chk("t1_consumed", 32'(bus.m_valid), 32'd0);

      // 3 then 7 cycles, one low cycle apart, ready low: second result dropped
      bus.m_ready = 1'b0;
      sense = 1'b1;
      repeat (3) tick();
      sense = 1'b0;
      tick();
      chk("t2_valid_a", 32'(bus.m_valid), 32'd1);
      chk("t2_count_a", 32'(bus.m_count), 32'd3);
      sense = 1'b1;
      repeat (7) tick();
      sense = 1'b0;
      tick();
      chk("t2_valid_b", 32'(bus.m_valid), 32'd1);
      chk("t2_count_b", 32'(bus.m_count), 32'd3);
      chk("t2_drop", 32'(drop), 32'd1);
      bus.m_ready = 1'b1;
      tick();
      chk("t2_drained", 32'(bus.m_valid), 32'd0);
      bus.m_ready = 1'b0;

      // completion coincides with a handshake of the buffered 4
      sense = 1'b1;
      repeat (4) tick();
      sense = 1'b0;
      tick();
      chk("t4_count_a", 32'(bus.m_count), 32'd4);
      sense = 1'b1;
      repeat (6) tick();
      sense = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      chk("t4_valid", 32'(bus.m_valid), 32'd1);
      chk("t4_count_b", 32'(bus.m_count), 32'd6);
      chk("t4_drop", 32'(drop), 32'd1);
      bus.m_ready = 1'b0;

      // second drop, then clear in the middle of a 10-cycle pulse
      sense = 1'b1;
      repeat (2) tick();
      sense = 1'b0;
      tick();
      chk("t6_drop2", 32'(drop), 32'd2);
      chk("t6_held", 32'(bus.m_count), 32'd6);
      sense = 1'b1;
      repeat (5) tick();
      chk("t6_meas_pre", 32'(meas), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t6_valid", 32'(bus.m_valid), 32'd0);
      chk("t6_drop0", 32'(drop), 32'd0);
      chk("t6_meas", 32'(meas), 32'd0);
      chk("t6_count_hold", 32'(bus.m_count), 32'd6);
      repeat (4) tick();
      chk("t6_meas_post", 32'(meas), 32'd0);
      sense = 1'b0;
      tick();
      tick();
      chk("t6_no_result", 32'(bus.m_valid), 32'd0);

      // async reset mid-pulse, sense held high across release
      sense = 1'b1;
      repeat (2) tick();
      chk("t5_meas_pre", 32'(meas), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_async_meas", 32'(meas), 32'd0);
      chk("t5_async_count", 32'(bus.m_count), 32'd0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("t5_meas_held", 32'(meas), 32'd0);
      sense = 1'b0;
      tick();
      chk("t5_no_result", 32'(bus.m_valid), 32'd0);
      bus.m_ready = 1'b1;
      sense = 1'b1;
      repeat (3) tick();
      sense = 1'b0;
      tick();
      chk("t5_valid", 32'(bus.m_valid), 32'd1);
      chk("t5_count", 32'(bus.m_count), 32'd3);
      tick();
      chk("t5_consumed", 32'(bus.m_valid), 32'd0);

      // 4-bit instance: saturation, recovery, exact all-ones boundary
      sense4 = 1'b1;
      repeat (20) tick();
      sense4 = 1'b0;
      tick();
      chk("w4_valid", 32'(bus4.m_valid), 32'd1);
      chk("w4_sat_count", 32'(bus4.m_count), 32'd15);
      chk("w4_sat_ovf", 32'(bus4.m_overflow), 32'd1);
      sense4 = 1'b1;
      repeat (2) tick();
      sense4 = 1'b0;
      tick();
      chk("w4_count2", 32'(bus4.m_count), 32'd2);
      chk("w4_ovf2", 32'(bus4.m_overflow), 32'd0);
      sense4 = 1'b1;
      repeat (15) tick();
      sense4 = 1'b0;
      tick();
      chk("w4_count15", 32'(bus4.m_count), 32'd15);
      chk("w4_ovf15", 32'(bus4.m_overflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
